// File: rtl/pkg_teclado.sv
// Shared types and constants for the keypad row-scanning controller.
package pkg_teclado;

   // Controller states: row scanning, press debounce, key held, release debounce.
   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      DEB_PRESS = 2'd1,
      PRESSED   = 2'd2,
      DEB_REL   = 2'd3
   } estado_t;

   localparam logic [3:0] FILA0    = 4'b0001;
   localparam logic [3:0] FILA1    = 4'b0010;
   localparam logic [3:0] FILA2    = 4'b0100;
   localparam logic [3:0] FILA3    = 4'b1000;
   localparam logic [3:0] COL_NONE = 4'b0000;

   // True when exactly one column line is active.
   function automatic logic es_one_hot(input logic [3:0] v);
      return (v != COL_NONE) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // Next row in the 0001 -> 0010 -> 0100 -> 1000 -> 0001 rotation.
   function automatic logic [3:0] sig_fila(input logic [3:0] f);
      return {f[2:0], f[3]};
   endfunction

endpackage

// File: rtl/module_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module module_sync_2ff #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two register stages; the first one may go metastable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/module_barrido_teclado.sv
// 4x4 keypad scanner: rotates the row drive, debounces press and release,
// and reports the accepted key as one-hot row/column with a valid pulse.
module module_barrido_teclado
   import pkg_teclado::*;
#(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_in,
   output logic [3:0] fila_out,
   output logic [3:0] fila,
   output logic [3:0] col,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned MAX_CNT = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
   localparam int unsigned CW      = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   estado_t       state;
   logic [CW-1:0] cnt;
   logic [3:0]    cap_col;
   logic [3:0]    col_s;

   module_sync_2ff #(
      .WIDTH (4)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (col_in),
      .q     (col_s)
   );

   // Scan/debounce FSM; every output is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SCAN;
         cnt       <= '0;
         cap_col   <= COL_NONE;
         fila_out  <= FILA0;
         fila      <= COL_NONE;
         col       <= COL_NONE;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               // Columns are only looked at in the last cycle of a dwell.
               if (cnt == SCAN_LAST) begin
                  cnt <= '0;
                  if (es_one_hot(col_s)) begin
                     cap_col <= col_s;
                     state   <= DEB_PRESS;
                  end else begin
                     fila_out <= sig_fila(fila_out);
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            DEB_PRESS: begin
               if (col_s == cap_col) begin
                  if (cnt == DEB_LAST) begin
                     cnt       <= '0;
                     key_valid <= 1'b1;
                     fila      <= fila_out;
                     col       <= cap_col;
                     key_held  <= 1'b1;
                     state     <= PRESSED;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end else begin
                  // Bounce or a changed key: give up and move on to the next row.
                  cnt      <= '0;
                  fila_out <= sig_fila(fila_out);
                  state    <= SCAN;
               end
            end
            PRESSED: begin
               if (col_s == COL_NONE) begin
                  cnt   <= '0;
                  state <= DEB_REL;
               end
            end
            DEB_REL: begin
               if (col_s == COL_NONE) begin
                  if (cnt == DEB_LAST) begin
                     cnt      <= '0;
                     key_held <= 1'b0;
                     fila_out <= sig_fila(fila_out);
                     state    <= SCAN;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end else begin
                  // Release glitch: still held, no new key reported.
                  cnt   <= '0;
                  state <= PRESSED;
               end
            end
            default: begin
               cnt   <= '0;
               state <= SCAN;
            end
         endcase
      end
   end

endmodule

// File: doc/module_barrido_teclado.md
MODULE_BARRIDO_TECLADO -- requirements
Module: module_barrido_teclado

Interface
REQ-001 SCAN_DIV, 1000, clock cycles each row stays driven during scanning; legal values are 4 or more.
REQ-002 DEBOUNCE_CNT, 2000, consecutive stable cycles required to accept a press or a release; legal values are 1 or more.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 col_in  input  4  raw keypad column lines: asynchronous, active-high, pulled low when idle.
REQ-006 fila_out  output  4  keypad row drive: one-hot, active-high.
REQ-007 fila  output  4  row of the accepted key: one-hot, active-high; feeds the keypad decoder.
REQ-008 col  output  4  column of the accepted key: one-hot, active-high; feeds the keypad decoder.
REQ-009 key_valid  output  1  one-cycle pulse marking a newly accepted key.
REQ-010 key_held  output  1  high from key acceptance until the release is debounced.

Function
REQ-011 col_in SHALL pass through a two-flop synchronizer; every internal decision uses only the synchronized value col_s.
REQ-012 The FSM SHALL have exactly four states: SCAN, DEB_PRESS, PRESSED, DEB_REL.
REQ-013 SCAN: fila_out SHALL hold each code for SCAN_DIV cycles, then rotate 0001 -> 0010 -> 0100 -> 1000 -> 0001.
REQ-014 SCAN: col_s SHALL be sampled only in the last cycle of each dwell.
REQ-015 At that sample, a one-hot col_s SHALL be captured, the rotation SHALL freeze, and the FSM SHALL enter DEB_PRESS.
REQ-016 At that sample, col_s = 0000 or a non-one-hot col_s (several keys in one row) SHALL be ignored, and scanning continues.
REQ-017 DEB_PRESS: the counter SHALL increment each cycle that col_s equals the captured column.
REQ-018 DEB_PRESS: any cycle with a differing col_s SHALL clear the counter, return to SCAN, and advance to the next row, with no key_valid.
REQ-019 On the DEBOUNCE_CNT-th consecutive match, the next cycle SHALL:
- pulse key_valid for exactly one cycle;
- load fila = fila_out and col = the captured column;
- set key_held = 1;
- enter PRESSED.
REQ-020 fila and col SHALL hold their value until the next accepted key or reset.
REQ-021 PRESSED: fila_out SHALL stay frozen; when col_s = 0000, the FSM SHALL enter DEB_REL with the counter cleared.
REQ-022 DEB_REL: the counter SHALL count consecutive cycles with col_s = 0000.
REQ-023 DEB_REL: any nonzero col_s SHALL return the FSM to PRESSED with no new key_valid.
REQ-024 On the DEBOUNCE_CNT-th consecutive zero cycle, the FSM SHALL clear key_held and return to SCAN, starting a fresh dwell on the next row.
REQ-025 key_valid SHALL fire at most once per physical press; auto-repeat SHALL NOT exist.
REQ-026 Counters SHALL be sized $clog2(max(SCAN_DIV, DEBOUNCE_CNT)+1) bits and SHALL never wrap.

Reset
REQ-027 While rst_n = 0, outputs SHALL immediately take: fila_out = 0001, fila = 0000, col = 0000, key_valid = 0, key_held = 0.
REQ-028 While rst_n = 0, internal state SHALL immediately take: synchronizer flops 0, counters 0, state SCAN.
REQ-029 A reset in any state, including mid-debounce, SHALL abort the operation with no key_valid pulse.
REQ-030 After reset deassertion, a full SCAN_DIV dwell on row 0001 SHALL begin.

Structure
REQ-031 Package pkg_teclado SHALL hold the state enum (SCAN, DEB_PRESS, PRESSED, DEB_REL).
REQ-032 pkg_teclado SHALL also hold the row one-hot constants FILA0..FILA3 and the idle code COL_NONE = 0000.
REQ-033 The two-flop synchronizer SHALL be a separate sub-module, module_sync_2ff, instantiated on the 4-bit col_in.

Verification (SCAN_DIV=8, DEBOUNCE_CNT=16; keypad model drives col_in = the key's column while fila_out holds the key's row)
REQ-034 No key pressed for 64 cycles -> fila_out steps 0001, 0010, 0100, 1000, 0001, each for 8 cycles; key_valid never asserts.
REQ-035 Key "5" (row 0010, column 0010) held -> exactly one key_valid with fila = 0010 and col = 0010; key_held = 1; fila_out frozen at 0010.
REQ-036 Press bouncing (col_in toggles every 3 cycles for 12 cycles, then stable) -> no key_valid during the bounce; a single key_valid follows a clean debounce.
REQ-037 col_in = 0011 on row 0100 -> ignored; scanning continues; key_valid = 0.
REQ-038 Release with a 5-cycle glitch, then a clean release -> no second key_valid; key_held falls 16 stable-zero cycles after the last glitch; scanning resumes at the next row.
REQ-039 rst_n pulled low mid-DEB_PRESS -> all outputs at reset values at once; scanning restarts at 0001 with no key_valid.
